// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request at a time against a word-addressed data memory.
// Byte/half loads are lane-extracted (little-endian) and extended; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_read_en,
    output logic        o_mem_write_en,
    output logic [31:0] o_mem_access_addr,
    output logic [31:0] o_mem_write_data,
    input  logic [31:0] i_mem_read_data
);

    localparam logic [29:0] LP_MEM_WORDS = 30'(MEM);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_RESP = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept = (r_state == S_IDLE) && i_req_valid;

    assign w_req_err = (i_req_size == 2'b11)
                    || ((i_req_size == 2'b01) && i_req_addr[0])
                    || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00))
                    || (i_req_addr[31:2] >= LP_MEM_WORDS);

    assign w_byte = i_mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = i_mem_read_data[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = i_mem_read_data;
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = i_mem_read_data;
        endcase
    end

    // Each byte lane takes new store data only when the access covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            logic w_lane_sel;
            logic [7:0] w_lane_data;
            assign w_lane_sel  = (r_size == 2'b00) ? (r_addr[1:0] == 2'(gi))
                                                   : (r_addr[1] == 1'((gi >> 1) & 1));
            assign w_lane_data = (r_size == 2'b00) ? r_wdata[7:0]
                                                   : r_wdata[8*(gi % 2) +: 8];
            assign w_merged[8*gi +: 8] = w_lane_sel ? w_lane_data
                                                    : i_mem_read_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= i_req_write;
                r_size   <= i_req_size;
                r_signed <= i_req_signed;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
                r_rdata  <= '0;
                r_err    <= w_req_err;
            end else if (r_state == S_RD) begin
                // r_wdata becomes the full merged word for the following WR cycle.
                if (r_write) begin
                    r_wdata <= w_merged;
                end else begin
                    r_rdata <= w_load_data;
                end
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        o_req_ready       = 1'b0;
        o_resp_valid      = 1'b0;
        o_resp_rdata      = '0;
        o_resp_err        = 1'b0;
        o_mem_read_en     = 1'b0;
        o_mem_write_en    = 1'b0;
        o_mem_access_addr = '0;
        o_mem_write_data  = '0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_req_err) begin
                        w_state_next = S_RESP;
                    end else if (!i_req_write || (i_req_size != 2'b10)) begin
                        w_state_next = S_RD;
                    end else begin
                        w_state_next = S_WR;
                    end
                end
            end
            S_RD: begin
                o_mem_read_en     = 1'b1;
                o_mem_access_addr = {2'b00, r_addr[31:2]};
                w_state_next      = r_write ? S_WR : S_RESP;
            end
            S_WR: begin
                o_mem_write_en    = 1'b1;
                o_mem_access_addr = {2'b00, r_addr[31:2]};
                o_mem_write_data  = r_wdata;
                w_state_next      = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_rdata = r_rdata;
                o_resp_err   = r_err;
                if (i_resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data memory plus a scoreboard of expected responses.
module tb_load_store_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [1:0]  i_req_size;
    logic        i_req_signed;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_mem_read_en;
    logic        o_mem_write_en;
    logic [31:0] o_mem_access_addr;
    logic [31:0] o_mem_write_data;
    logic [31:0] i_mem_read_data;

    load_store_unit #(.MEM(256)) u_dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_write       (i_req_write),
        .i_req_size        (i_req_size),
        .i_req_signed      (i_req_signed),
        .i_req_addr        (i_req_addr),
        .i_req_wdata       (i_req_wdata),
        .o_resp_valid      (o_resp_valid),
        .i_resp_ready      (i_resp_ready),
        .o_resp_rdata      (o_resp_rdata),
        .o_resp_err        (o_resp_err),
        .o_mem_read_en     (o_mem_read_en),
        .o_mem_write_en    (o_mem_write_en),
        .o_mem_access_addr (o_mem_access_addr),
        .o_mem_write_data  (o_mem_write_data),
        .i_mem_read_data   (i_mem_read_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [256];
    int          n_vec;
    int          n_err;
    logic        overlap_seen;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_mem_write_en) mem[o_mem_access_addr[7:0]] <= o_mem_write_data;
        if (o_mem_read_en && o_mem_write_en) overlap_seen = 1'b1;
    end

    assign i_mem_read_data = (o_mem_access_addr < 32'd256) ? mem[o_mem_access_addr[7:0]] : 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
        if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
        return word;
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns at #1 after the response handshake.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                           input int exp_rds, input int exp_wrs, input logic [31:0] exp_wd);
        exp_t        e;
        exp_t        got_e;
        int          lat;
        int          rds;
        int          wrs;
        logic [31:0] seen_ra;
        logic [31:0] seen_wa;
        logic [31:0] seen_wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_size   = sz;
        i_req_signed = sg;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        check_val({tag, "/req_ready"}, {31'h0, o_req_ready}, 32'h1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        lat = 1; rds = 0; wrs = 0;
        seen_ra = 32'h0; seen_wa = 32'h0; seen_wd = 32'h0;
        while (!o_resp_valid && lat <= 10) begin
            if (o_mem_read_en)  begin rds++; seen_ra = o_mem_access_addr; end
            if (o_mem_write_en) begin wrs++; seen_wa = o_mem_access_addr; seen_wd = o_mem_write_data; end
            @(posedge i_clk); #1;
            lat++;
        end
        got_e = sb_q.pop_front();
        check_val({tag, "/resp_valid"}, {31'h0, o_resp_valid}, 32'h1);
        check_val({tag, "/rdata"}, o_resp_rdata, got_e.rdata);
        check_val({tag, "/err"}, {31'h0, o_resp_err}, {31'h0, got_e.err});
        check_val({tag, "/latency"}, 32'(lat), 32'(got_e.lat));
        check_val({tag, "/rd_pulses"}, 32'(rds), 32'(exp_rds));
        check_val({tag, "/wr_pulses"}, 32'(wrs), 32'(exp_wrs));
        if (exp_rds > 0) check_val({tag, "/rd_addr"}, seen_ra, {2'b00, addr[31:2]});
        if (exp_wrs > 0) begin
            check_val({tag, "/wr_addr"}, seen_wa, {2'b00, addr[31:2]});
            check_val({tag, "/wr_data"}, seen_wd, exp_wd);
        end
        $display("txn %-14s wr=%0b sz=%0d sg=%0b addr=%h wd=%h -> rdata=%h err=%0b lat=%0d",
                 tag, wr, sz, sg, addr, wd, o_resp_rdata, o_resp_err, lat);
        @(posedge i_clk); #1;
    endtask

    initial begin
        exp_t e;
        exp_t got_e;
        logic [31:0] held;
        n_vec = 0;
        n_err = 0;
        overlap_seen = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[0]   <= 32'd4;
        mem[1]   <= 32'd10;
        mem[255] <= 32'h8765_4321;
        i_rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_write = 1'b0; i_req_size = 2'b00; i_req_signed = 1'b0;
        i_req_addr = 32'h0; i_req_wdata = 32'h0; i_resp_ready = 1'b1;
        @(posedge i_clk); @(posedge i_clk); #1;

        check_val("rst/req_ready", {31'h0, o_req_ready}, 32'h1);
        check_val("rst/resp_valid", {31'h0, o_resp_valid}, 32'h0);
        check_val("rst/rd_en", {31'h0, o_mem_read_en}, 32'h0);
        check_val("rst/wr_en", {31'h0, o_mem_write_en}, 32'h0);
        check_val("rst/addr", o_mem_access_addr, 32'h0);
        check_val("rst/wdata", o_mem_write_data, 32'h0);
        check_val("rst/rdata", o_resp_rdata, 32'h0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_req("ld_w_4",     1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_000A, 1'b0, 2, 1, 0, 32'h0);
        run_req("st_w_8",     1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEAD_BEEF);
        check_val("mem2_after_st_w", mem[2], 32'hDEAD_BEEF);
        run_req("ld_b_B_s",   1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 1, 0, 32'h0);
        run_req("ld_b_B_u",   1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h0000_00DE, 1'b0, 2, 1, 0, 32'h0);
        run_req("ld_h_A_s",   1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 1, 0, 32'h0);
        run_req("ld_h_A_u",   1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h0000_DEAD, 1'b0, 2, 1, 0, 32'h0);
        for (int l = 0; l < 4; l++) begin
            for (int s = 0; s < 2; s++) begin
                run_req($sformatf("ld_b_lane%0d_%0d", l, s), 1'b0, 2'b00, s[0], 32'h8 + 32'(l), 32'h0,
                        ref_load(32'hDEAD_BEEF, 2'b00, s[0], 2'(l)), 1'b0, 2, 1, 0, 32'h0);
            end
        end
        run_req("ld_h_8_s",   1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'hFFFF_BEEF, 1'b0, 2, 1, 0, 32'h0);
        run_req("st_b_9",     1'b1, 2'b00, 1'b0, 32'h9, 32'hAAAA_AA55, 32'h0, 1'b0, 3, 1, 1, 32'hDEAD_55EF);
        check_val("mem2_after_st_b", mem[2], 32'hDEAD_55EF);
        run_req("st_h_8",     1'b1, 2'b01, 1'b0, 32'h8, 32'hABCD_1234, 32'h0, 1'b0, 3, 1, 1, 32'hDEAD_1234);
        run_req("ld_w_8",     1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_1234, 1'b0, 2, 1, 0, 32'h0);
        run_req("st_h_E",     1'b1, 2'b01, 1'b0, 32'hE, 32'h0000_CAFE, 32'h0, 1'b0, 3, 1, 1, 32'hCAFE_0000);
        run_req("ld_w_3FC",   1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h8765_4321, 1'b0, 2, 1, 0, 32'h0);

        run_req("err_w_2",    1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_h_5",    1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_size11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_oor",    1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_st_oor", 1'b1, 2'b00, 1'b0, 32'h401, 32'h11, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_st_h_1", 1'b1, 2'b01, 1'b0, 32'h1, 32'h1111, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        check_val("mem0_after_errs", mem[0], 32'd4);

        // Back-pressure: response held with resp_ready low while a new request waits.
        i_resp_ready = 1'b0;
        e.rdata = 32'h0000_000A; e.err = 1'b0; e.lat = 2;
        sb_q.push_back(e);
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_size = 2'b10; i_req_signed = 1'b0; i_req_addr = 32'h4;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        got_e = sb_q.pop_front();
        check_val("bp/resp_valid", {31'h0, o_resp_valid}, 32'h1);
        check_val("bp/rdata", o_resp_rdata, got_e.rdata);
        held = o_resp_rdata;
        e.rdata = 32'd4; e.err = 1'b0; e.lat = 2;
        sb_q.push_back(e);
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            check_val($sformatf("bp/hold%0d_valid", c), {31'h0, o_resp_valid}, 32'h1);
            check_val($sformatf("bp/hold%0d_rdata", c), o_resp_rdata, held);
            check_val($sformatf("bp/hold%0d_ready", c), {31'h0, o_req_ready}, 32'h0);
            check_val($sformatf("bp/hold%0d_mem", c), {30'h0, o_mem_read_en, o_mem_write_en}, 32'h0);
        end
        $display("txn bp_hold       5 cycles held, rdata=%h", o_resp_rdata);
        i_resp_ready = 1'b1;
        @(posedge i_clk); #1;
        check_val("bp/idle_valid", {31'h0, o_resp_valid}, 32'h0);
        check_val("bp/idle_ready", {31'h0, o_req_ready}, 32'h1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        check_val("bp/next_rd_en", {31'h0, o_mem_read_en}, 32'h1);
        check_val("bp/next_rd_addr", o_mem_access_addr, 32'h0);
        @(posedge i_clk); #1;
        got_e = sb_q.pop_front();
        check_val("bp/next_valid", {31'h0, o_resp_valid}, 32'h1);
        check_val("bp/next_rdata", o_resp_rdata, got_e.rdata);
        $display("txn bp_next       ld_w addr=0 -> rdata=%h", o_resp_rdata);
        @(posedge i_clk); #1;

        // Reset asserted during the WR cycle of a byte store aborts it.
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_size = 2'b00; i_req_addr = 32'h0; i_req_wdata = 32'h77;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        check_val("rstwr/wr_en_before", {31'h0, o_mem_write_en}, 32'h1);
        #2 i_rst_n = 1'b0;
        #1;
        check_val("rstwr/wr_en", {31'h0, o_mem_write_en}, 32'h0);
        check_val("rstwr/req_ready", {31'h0, o_req_ready}, 32'h1);
        check_val("rstwr/resp_valid", {31'h0, o_resp_valid}, 32'h0);
        check_val("rstwr/addr", o_mem_access_addr, 32'h0);
        @(posedge i_clk); @(posedge i_clk); #1;
        check_val("rstwr/mem0", mem[0], 32'd4);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check_val("rstwr/ready_after", {31'h0, o_req_ready}, 32'h1);
        check_val("rstwr/valid_after", {31'h0, o_resp_valid}, 32'h0);
        $display("txn rst_in_wr     store aborted, mem[0]=%h", mem[0]);
        run_req("ld_w_0_post", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'd4, 1'b0, 2, 1, 0, 32'h0);

        check_val("rd_wr_exclusive", {31'h0, overlap_seen}, 32'h0);
        check_val("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port. Accepts one load/store request at a time from the MEM pipeline stage over a valid/ready handshake.
- Drives the word-addressed data memory (combinational read, posedge write).
- Implements byte/halfword/word access:
  - little-endian lane extraction and sign/zero extension for loads;
  - read-modify-write for sub-word stores.
- Returns a response with read data and an error flag.

Parameters:
MEM, 256, number of 32-bit words in the attached data memory; word index >= MEM is out of range.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size or out-of-range access
mem_read_en  output  1  to data memory
mem_write_en  output  1  to data memory
mem_access_addr  output  32  word index = {2'b00, addr[31:2]}
mem_write_data  output  32  full word to write
mem_read_data  input  32  combinational read data from memory

Behaviour:
- Reset (async, active-low): state IDLE; every output 0 except req_ready=1; all captured registers cleared.
- Reset asserted mid-operation aborts immediately: mem_write_en drops with no pending write, and no response is issued.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1; request accepted on a clock edge with req_valid=1. Latch write, size, signed, addr, wdata.
  - Error if any of the following, then go to RESP with resp_err=1, resp_rdata=0, and no memory access:
    - size=11;
    - half with addr[0]=1;
    - word with addr[1:0]!=0;
    - addr[31:2] >= MEM.
  - Otherwise: load -> RD; word store -> WR; byte/half store -> RD (read-modify-write).
- RD:
  - mem_read_en=1 and mem_access_addr=word index; capture mem_read_data at the edge.
  - Load -> RESP with extracted data.
  - Sub-word store -> WR with the merged word.
- Load extraction:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half = bits [16*addr[1]+15 : 16*addr[1]];
  - extend to 32 bits per req_signed; word loads are returned unchanged.
- Sub-word store merge: replace only the addressed byte/half lane with req_wdata[7:0]/[15:0]; all other lanes keep the value read in RD.
- WR: mem_write_en=1, mem_access_addr held, mem_write_data = full word (wdata for word stores, merged word for sub-word stores). One cycle only, then RESP.
- RESP:
  - resp_valid=1, req_ready=0; resp_rdata/resp_err stable until the edge with resp_ready=1, then IDLE.
  - resp_ready may be held high continuously.
  - The next request is accepted no earlier than the cycle after the response handshake (no overlap).
- mem_read_en and mem_write_en are never high together and are 0 outside RD/WR; mem_access_addr and mem_write_data are 0 in IDLE.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-pressure: resp_ready low holds RESP indefinitely with no memory activity.

Test Plan:
- Memory reset image word0=4, word1=10. Load word addr 0x4, signed=0 -> mem_read_en one cycle at index 1; resp_rdata=0x0000000A, resp_err=0, resp_valid 2 cycles after accept.
- Store word 0xDEADBEEF to addr 0x8, then load byte addr 0xB signed=1 -> resp_rdata=0xFFFFFFDE. Same load signed=0 -> 0x000000DE. Load half addr 0xA signed=1 -> 0xFFFFDEAD.
- Store byte 0x55 to addr 0x9 over 0xDEADBEEF -> RD then WR cycles; mem_write_data=0xDEAD55EF; response 3 cycles after accept. Store half 0x1234 to addr 0x8 -> word becomes 0xDEAD1234.
- Errors, each giving resp_err=1 one cycle after accept with no mem_read_en/mem_write_en pulses:
  - load word addr 0x2;
  - load half addr 0x5;
  - size=11;
  - addr 0x400 with MEM=256.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and data stable, req_ready=0, a new req_valid ignored; raise resp_ready -> IDLE the next cycle and the pending request is accepted.
- Assert reset during the WR cycle of a byte store -> outputs immediately at reset values, target word unchanged, no resp_valid; after release, req_ready=1.
